// File: rtl/mb_rx_flit_if.sv
// Mainband receive bus: sampled UI pairs in, flits out with ready/valid.
// Ports: ui_valid_i/ui_data_i (sampler to deserialiser), flit_* (to adapter).
interface mb_rx_flit_if #(
    parameter int NUM_LANES  = 16,
    parameter int FLIT_BYTES = 64
);
    logic [1:0]              ui_valid_i;
    logic [2*NUM_LANES-1:0]  ui_data_i;
    logic                    flit_ready_i;
    logic                    flit_valid_o;
    logic [8*FLIT_BYTES-1:0] flit_data_o;

    // master: sampler + adapter side driving the deserialiser
    modport master (
        output ui_valid_i, ui_data_i, flit_ready_i,
        input  flit_valid_o, flit_data_o
    );

    // slave: the deserialiser itself
    modport slave (
        input  ui_valid_i, ui_data_i, flit_ready_i,
        output flit_valid_o, flit_data_o
    );
endinterface

// File: rtl/mb_rx_flit_deser.sv
// Mainband RX: checks 8-UI valid framing, deserialises lanes LSB-first into
// flits of FLIT_BYTES bytes and queues them in a FIFO_DEPTH-entry flit FIFO.
// Ports: clk, reset (sync, active-high), bus (mb_rx_flit_if.slave),
//   lane_rev_i, clear_err_i, fifo_count_o, framing_err_o, overflow_o.
// Optional: define MB_RX_ERR_CNT_EN to add the 8-bit saturating err_count_o.
module mb_rx_flit_deser #(
    parameter int NUM_LANES  = 16,
    parameter int FLIT_BYTES = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    mb_rx_flit_if.slave                   bus,
    input  logic                          lane_rev_i,
    input  logic                          clear_err_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          framing_err_o,
    output logic                          overflow_o
`ifdef MB_RX_ERR_CNT_EN
    ,
    output logic [7:0]                    err_count_o
`endif
);

    localparam int BLOCKS = FLIT_BYTES / NUM_LANES;
    localparam int BW     = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int FW     = 8 * FLIT_BYTES;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          rev_q, rev_d;
    logic [FW-1:0] buf_q, buf_d;
    logic [FW-1:0] cap;
    logic          rev_eff;
    logic [1:0]    exp_v;
    logic          fe_evt;
    logic          push;

    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, head_idx;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, pop, wr_en, drop;
    logic          ferr_q, ovf_q;

    // ---------------- framing FSM and deserialiser ----------------
    // phase/block counters sit at 0 in IDLE, so cap is valid for P0 too
    always_comb begin
        rev_eff = (state_q == S_IDLE) ? lane_rev_i : rev_q;
        cap     = buf_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            cap[((int'(blk_q) * NUM_LANES
                  + (rev_eff ? (NUM_LANES - 1 - l) : l)) * 8
                 + 2 * int'(phase_q)) +: 2] =
                {bus.ui_data_i[NUM_LANES + l], bus.ui_data_i[l]};
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        blk_d   = blk_q;
        rev_d   = rev_q;
        buf_d   = buf_q;
        fe_evt  = 1'b0;
        push    = 1'b0;
        exp_v   = phase_q[1] ? 2'b00 : 2'b11;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ui_valid_i == 2'b11) begin
                    state_d = S_RECV;
                    phase_d = 2'd1;
                    blk_d   = '0;
                    rev_d   = lane_rev_i;
                    buf_d   = cap;
                end else if (bus.ui_valid_i != 2'b00) begin
                    fe_evt = 1'b1;
                end
            end
            S_RECV: begin
                if (bus.ui_valid_i != exp_v) begin
                    fe_evt  = 1'b1;
                    state_d = S_IDLE;
                    phase_d = 2'd0;
                    blk_d   = '0;
                end else begin
                    buf_d = cap;
                    if (phase_q == 2'd3) begin
                        phase_d = 2'd0;
                        if (blk_q == BW'(BLOCKS - 1)) begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                            blk_d   = '0;
                        end else begin
                            blk_d = blk_q + 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= 2'd0;
            blk_q   <= '0;
            rev_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            blk_q   <= blk_d;
            rev_q   <= rev_d;
            buf_q   <= buf_d;
        end
    end

    // ---------------- flit FIFO ----------------
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && bus.flit_ready_i;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= cap;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // when empty, the last popped entry sits just behind the read pointer
    assign head_idx         = empty ? (rd_ptr_q - 1'b1) : rd_ptr_q;
    assign bus.flit_data_o  = mem_q[head_idx];
    assign bus.flit_valid_o = !empty;
    assign fifo_count_o     = count_q;

    // ---------------- sticky flags ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (fe_evt) ferr_q <= 1'b1;
            else if (clear_err_i) ferr_q <= 1'b0;
            if (drop) ovf_q <= 1'b1;
            else if (clear_err_i) ovf_q <= 1'b0;
        end
    end

    assign framing_err_o = ferr_q;
    assign overflow_o    = ovf_q;

`ifdef MB_RX_ERR_CNT_EN
    logic [7:0] errcnt_q, errcnt_d;
    logic [1:0] inc;
    logic [8:0] sum;

    // a clear in the same cycle as an event restarts the count from 0
    always_comb begin
        inc      = {1'b0, fe_evt} + {1'b0, drop};
        sum      = (clear_err_i ? 9'd0 : {1'b0, errcnt_q}) + {7'd0, inc};
        errcnt_d = errcnt_q;
        if (inc != 2'd0) errcnt_d = sum[8] ? 8'hFF : sum[7:0];
        else if (clear_err_i) errcnt_d = 8'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) errcnt_q <= 8'd0;
        else errcnt_q <= errcnt_d;
    end

    assign err_count_o = errcnt_q;
`endif

endmodule

// File: doc/mb_rx_flit_deser.md
Name: mb_rx_flit_deser

Overview:
- Parametrised successor to the mainband receive path.
- Takes per-clock pairs of already-sampled UIs (valid plus NUM_LANES data lanes) from the pad sampler.
- Checks the 8-UI valid framing and deserialises each lane LSB-first into bytes.
- Assembles flits of FLIT_BYTES bytes, queues them in a flit FIFO and presents them to the adapter side with a ready/valid handshake; optional lane reversal.

Parameters:
- NUM_LANES, 16, data lanes; bytes per 8-UI block; FLIT_BYTES must be a multiple of NUM_LANES.
- FLIT_BYTES, 64, bytes per flit; BLOCKS = FLIT_BYTES/NUM_LANES.
- FIFO_DEPTH, 4, flit FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  block clock; one clock = 2 UI.
- reset  in  1  synchronous, active-high.
- ui_valid_i  in  2  valid samples; bit0 = earlier UI, bit1 = later UI.
- ui_data_i  in  2*NUM_LANES  [NUM_LANES-1:0] = earlier UI, upper half = later UI; bit l = lane l.
- lane_rev_i  in  1  1 = lane l maps to byte slot NUM_LANES-1-l.
- flit_ready_i  in  1  consumer accepts head flit.
- flit_valid_o  out  1  FIFO non-empty.
- flit_data_o  out  8*FLIT_BYTES  head flit; byte n at [8n+7:8n].
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- framing_err_o  out  1  sticky framing error.
- overflow_o  out  1  sticky flit drop.
- clear_err_i  in  1  clears sticky flags.

Behaviour:
- Reset (synchronous): flit_valid_o=0, flit_data_o=0, fifo_count_o=0, framing_err_o=0, overflow_o=0; FSM to IDLE; partial flit discarded. This applies mid-flit as well.
- Block framing: 8 UI = 4 clocks, phases P0..P3. Required ui_valid_i: P0=11, P1=11, P2=00, P3=00. At phase p, UI 2p goes to bit 2p and UI 2p+1 goes to bit 2p+1 of each lane's byte.
- Byte index = block*NUM_LANES + slot, where slot = l, or NUM_LANES-1-l when lane_rev_i=1. lane_rev_i is latched at flit start and held for the whole flit.
- FSM states:
  - IDLE:
    - ui_valid_i=11: latch P0 bits, go to RECV (block 0, P1).
    - ui_valid_i=00: stay in IDLE.
    - ui_valid_i=01 or 10: set framing_err_o, stay in IDLE.
  - RECV:
    - Tracks block counter 0..BLOCKS-1 and phase counter.
    - Any phase whose valid mismatches the pattern: set framing_err_o, discard the partial flit, go to IDLE.
    - Exception: a mismatch in P0 of a non-first block that reads 11 is simply a correct block continuation.
    - Blocks within one flit must be back-to-back; a 00 at P0 of block b>0 is a framing error.
  - After P3 of the last block: push the flit, go to IDLE.
  - A new flit may start on the very next clock (back-to-back flits, zero gap).
- Latency: first P0 sampled at edge T → flit written at edge T+4*BLOCKS-1 → flit_valid_o high after that edge (edge T+15 for the defaults). Only if the FIFO was empty.
- FIFO:
  - Pop on flit_valid_o && flit_ready_i.
  - Push while full without a same-cycle pop: flit dropped, overflow_o set, contents unchanged.
  - Full plus pop plus push in the same cycle: push accepted, count unchanged.
  - Pop while empty: ignored.
  - flit_data_o always shows the head entry; holds its last value when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: clear_err_i clears them on the next edge; a same-cycle set event wins over clear.

Optional Feature:
- Macro MB_RX_ERR_CNT_EN.
- Defined:
  - Adds output err_count_o (8 bits, reset 0).
  - Increments by 1 per framing error event and per dropped flit; increments by 2 if both occur in the same cycle.
  - Saturates at 255.
  - clear_err_i zeroes it; a same-cycle increment wins and loads the increment value.
- Undefined: port absent, no counter logic.

Test Plan:
- Defaults, lane_rev_i=0. Send a flit with byte0=8'hFF, byte1="e", byte8=8'hFE, bytes 48..63=" ", with correct framing, starting at edge T. Expect flit_valid_o=1 after edge T+15, flit_data_o[7:0]=8'hFF, [71:64]=8'hFE, fifo_count_o=1.
- Same flit with lane_rev_i=1 → flit_data_o[127:120]=8'hFF, [63:56]=8'hFE.
- Hold flit_ready_i=0 and send 5 back-to-back flits. Expect fifo_count_o=4, overflow_o=1 after the 5th flit, head = flit 1; pops then return flits 1..4 in order.
- Drive ui_valid_i=00 at P1 of block 2. Expect framing_err_o=1, no push. A following clean flit is received correctly. clear_err_i=1 then gives framing_err_o=0.
- Assert reset for 1 clock during block 1. Expect all outputs 0 next cycle and no partial flit pushed. A subsequent flit has 15-clock latency.
- With MB_RX_ERR_CNT_EN defined: 3 framing errors plus 1 overflow → err_count_o=4; 300 errors → 255.
